// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer: state encoding, default width
// and small decode helpers used by the controller.
package count_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // A start is only listened to while no run is in progress.
    function automatic logic can_start(input logic [1:0] s);
        return (s == S_IDLE) || (s == S_DONE);
    endfunction

    function automatic logic is_busy(input logic [1:0] s);
        return (s == S_RUN) || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/count_sequencer_counter.sv
// seq_counter: synchronous up-counter datapath with clear taking priority
// over enable.
module seq_counter
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: commanded one-shot / periodic run controller around the
// seq_counter datapath, with pause/hold, abort and a saturating period tally.
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             periodic,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] periods
);

    localparam logic [WIDTH-1:0] PMAX = '1;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] target_r;
    logic             periodic_r;
    logic             accept, at_term, run_eval, term_evt;
    logic             cnt_en, cnt_clr;

    // abort outranks start, so a simultaneous start in IDLE/DONE is dropped
    assign accept   = can_start(state) && start && (target != '0) && !abort;
    assign at_term  = (q == target_r);
    assign run_eval = (state == S_RUN) && !pause && !abort;
    assign term_evt = run_eval && at_term;
    assign cnt_en   = run_eval && !at_term;
    assign cnt_clr  = abort || accept || (term_evt && periodic_r);

    seq_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .q     (q)
    );

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (accept) state_nx = S_RUN;
                S_RUN: begin
                    if (pause)                        state_nx = S_HOLD;
                    else if (at_term && !periodic_r)  state_nx = S_DONE;
                end
                // leaving HOLD spends one edge; evaluation resumes after it
                S_HOLD: if (!pause) state_nx = S_RUN;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            periods    <= '0;
            target_r   <= '0;
            periodic_r <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= is_busy(state_nx);
            done  <= term_evt;
            if (accept) begin
                target_r   <= target;
                periodic_r <= periodic;
                periods    <= '0;
            end else if (term_evt && (periods != PMAX)) begin
                periods <= periods + 1'b1;
            end
        end
    end

endmodule
